// File: rtl/axis_packet_switch.sv
`default_nettype none
// ============================================================================
// Module  : axis_packet_switch
// Brief   : N-to-1 AXI4-Stream switch with packet-safe source/mode switching
//           and optional constant-data substitution on a registered output.
// Revision: 1.0 - initial release
// ============================================================================
module axis_packet_switch #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CHANNELS         = 4,
  parameter int SEL_WIDTH        = 2,
  parameter int DROP_UNSELECTED  = 0
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [SEL_WIDTH-1:0]                 cfg_sel,
  input  logic                                 cfg_mode,
  input  logic [AXIS_TDATA_WIDTH-1:0]          default_value,
  input  logic [CHANNELS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS-1:0]                  s_axis_tvalid,
  input  logic [CHANNELS-1:0]                  s_axis_tlast,
  output logic [CHANNELS-1:0]                  s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]          m_axis_tdata,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic [SEL_WIDTH-1:0]                 sts_active_sel,
  output logic                                 sts_locked,
  output logic [31:0]                          sts_packets
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic       DROP_RDY  = (DROP_UNSELECTED != 0);

  logic [0:0]                  state_q, state_d;
  logic [SEL_WIDTH-1:0]        active_sel_q, active_sel_d;
  logic                        active_mode_q, active_mode_d;
  logic [AXIS_TDATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                        m_tvalid_q, m_tvalid_d;
  logic                        m_tlast_q, m_tlast_d;
  logic [31:0]                 packets_q, packets_d;

  logic [SEL_WIDTH-1:0]        sel_eff;
  logic                        mode_eff;
  logic                        sel_in_range;
  logic                        load;
  logic                        accept;
  logic                        sel_tvalid;
  logic                        sel_tlast;
  logic [AXIS_TDATA_WIDTH-1:0] sel_tdata;

  // Configuration is only sampled between packets; inside a packet the
  // captured selection holds so a packet is never split across sources.
  always_comb begin
    sel_eff  = cfg_sel;
    mode_eff = cfg_mode;
    if (state_q == ST_LOCKED) begin
      sel_eff  = active_sel_q;
      mode_eff = active_mode_q;
    end
  end

  assign sel_in_range = ({{(32-SEL_WIDTH){1'b0}}, sel_eff} < CHANNELS);
  assign load         = !m_tvalid_q || m_axis_tready;

  always_comb begin
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tdata  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_in_range && (sel_eff == SEL_WIDTH'(i))) begin
        sel_tvalid = s_axis_tvalid[i];
        sel_tlast  = s_axis_tlast[i];
        sel_tdata  = s_axis_tdata[i*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
      end
    end
  end

  // tready never looks at tvalid, keeping the ready path free of loops.
  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_tready
      assign s_axis_tready[i] = (sel_in_range && (sel_eff == SEL_WIDTH'(i))) ? load : DROP_RDY;
    end
  endgenerate

  assign accept = sel_tvalid && load;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept && !sel_tlast) state_d = ST_LOCKED;
      ST_LOCKED: if (accept && sel_tlast)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sts_locked     = (state_q == ST_LOCKED);
    sts_active_sel = sel_eff;
  end

  always_comb begin
    active_sel_d  = active_sel_q;
    active_mode_d = active_mode_q;
    m_tdata_d     = m_tdata_q;
    m_tlast_d     = m_tlast_q;
    m_tvalid_d    = m_tvalid_q;
    packets_d     = packets_q;
    if ((state_q == ST_IDLE) && accept && !sel_tlast) begin
      active_sel_d  = cfg_sel;
      active_mode_d = cfg_mode;
    end
    if (accept) begin
      m_tdata_d  = mode_eff ? default_value : sel_tdata;
      m_tlast_d  = sel_tlast;
      m_tvalid_d = 1'b1;
      if (sel_tlast) packets_d = packets_q + 32'd1;
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      active_sel_q  <= '0;
      active_mode_q <= 1'b0;
      m_tdata_q     <= '0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      packets_q     <= '0;
    end else begin
      active_sel_q  <= active_sel_d;
      active_mode_q <= active_mode_d;
      m_tdata_q     <= m_tdata_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
      packets_q     <= packets_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign sts_packets   = packets_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_switch.sv
`default_nettype none
// ============================================================================
// Module  : tb_axis_packet_switch
// Brief   : Directed self-checking bench; stall instance plus drop instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axis_packet_switch;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  // Instance A: 4 channels, unselected stalled
  logic [1:0]   a_cfg_sel;
  logic         a_cfg_mode;
  logic [31:0]  a_default;
  logic [127:0] a_s_tdata;
  logic [3:0]   a_s_tvalid, a_s_tlast, a_s_tready;
  logic [31:0]  a_m_tdata;
  logic         a_m_tvalid, a_m_tlast, a_m_tready;
  logic [1:0]   a_sts_sel;
  logic         a_sts_locked;
  logic [31:0]  a_sts_packets;

  // Instance B: 4 channels, 3-bit select, unselected drained
  logic [2:0]   b_cfg_sel;
  logic         b_cfg_mode;
  logic [31:0]  b_default;
  logic [127:0] b_s_tdata;
  logic [3:0]   b_s_tvalid, b_s_tlast, b_s_tready;
  logic [31:0]  b_m_tdata;
  logic         b_m_tvalid, b_m_tlast, b_m_tready;
  logic [2:0]   b_sts_sel;
  logic         b_sts_locked;
  logic [31:0]  b_sts_packets;

  axis_packet_switch #(.AXIS_TDATA_WIDTH(32), .CHANNELS(4), .SEL_WIDTH(2), .DROP_UNSELECTED(0)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .cfg_sel(a_cfg_sel), .cfg_mode(a_cfg_mode),
    .default_value(a_default), .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid),
    .s_axis_tlast(a_s_tlast), .s_axis_tready(a_s_tready), .m_axis_tdata(a_m_tdata),
    .m_axis_tvalid(a_m_tvalid), .m_axis_tlast(a_m_tlast), .m_axis_tready(a_m_tready),
    .sts_active_sel(a_sts_sel), .sts_locked(a_sts_locked), .sts_packets(a_sts_packets)
  );

  axis_packet_switch #(.AXIS_TDATA_WIDTH(32), .CHANNELS(4), .SEL_WIDTH(3), .DROP_UNSELECTED(1)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .cfg_sel(b_cfg_sel), .cfg_mode(b_cfg_mode),
    .default_value(b_default), .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid),
    .s_axis_tlast(b_s_tlast), .s_axis_tready(b_s_tready), .m_axis_tdata(b_m_tdata),
    .m_axis_tvalid(b_m_tvalid), .m_axis_tlast(b_m_tlast), .m_axis_tready(b_m_tready),
    .sts_active_sel(b_sts_sel), .sts_locked(b_sts_locked), .sts_packets(b_sts_packets)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  // Drive a single beat on one channel of instance A, all others idle.
  task automatic a_beat(input int ch, input logic [31:0] d, input logic l);
    a_s_tvalid           = '0;
    a_s_tlast            = '0;
    a_s_tdata[ch*32 +: 32] = d;
    a_s_tvalid[ch]       = 1'b1;
    a_s_tlast[ch]        = l;
  endtask

  logic [31:0] beats [5];
  int          pat   [12];
  logic [31:0] held;
  logic        was_stalled;
  int          src, outn;
  logic        acc;

  initial begin
    aresetn    = 1'b0;
    a_cfg_sel  = '0; a_cfg_mode = 1'b0; a_default = '0;
    a_s_tdata  = '0; a_s_tvalid = '0; a_s_tlast = '0; a_m_tready = 1'b1;
    b_cfg_sel  = '0; b_cfg_mode = 1'b0; b_default = '0;
    b_s_tdata  = '0; b_s_tvalid = '0; b_s_tlast = '0; b_m_tready = 1'b1;
    repeat (3) tick();
    check("rst_valid",   a_m_tvalid,    1'b0);
    check("rst_tdata",   a_m_tdata,     32'h0);
    check("rst_tlast",   a_m_tlast,     1'b0);
    check("rst_packets", a_sts_packets, 32'd0);
    check("rst_locked",  a_sts_locked,  1'b0);
    aresetn = 1'b1;
    tick();

    // Pass-through on channel 2
    a_cfg_sel = 2'd2; a_cfg_mode = 1'b0; a_m_tready = 1'b1;
    a_beat(2, 32'h11, 1'b0); #1;
    check("pt_tready", a_s_tready, 4'b0100);
    tick();
    check("pt_d0",     a_m_tdata,  32'h11);
    check("pt_v0",     a_m_tvalid, 1'b1);
    check("pt_l0",     a_m_tlast,  1'b0);
    check("pt_lock0",  a_sts_locked, 1'b1);
    a_beat(2, 32'h22, 1'b0); tick();
    check("pt_d1",     a_m_tdata,  32'h22);
    a_beat(2, 32'h33, 1'b1); tick();
    check("pt_d2",     a_m_tdata,  32'h33);
    check("pt_l2",     a_m_tlast,  1'b1);
    check("pt_pkts",   a_sts_packets, 32'd1);
    check("pt_unlock", a_sts_locked, 1'b0);
    a_s_tvalid = '0; tick();
    check("pt_drain",  a_m_tvalid, 1'b0);

    // Packet lock: cfg_sel moves 1->3 inside a packet from channel 1
    a_cfg_sel = 2'd1;
    a_beat(1, 32'hA1, 1'b0);
    a_s_tdata[3*32 +: 32] = 32'hC3; a_s_tvalid[3] = 1'b1; a_s_tlast[3] = 1'b1;
    tick();
    check("lk_d0",    a_m_tdata, 32'hA1);
    check("lk_lock",  a_sts_locked, 1'b1);
    a_cfg_sel = 2'd3;
    a_s_tdata[32 +: 32] = 32'hA2; #1;
    check("lk_tready", a_s_tready, 4'b0010);
    check("lk_sel",    a_sts_sel,  2'd1);
    tick();
    check("lk_d1",    a_m_tdata, 32'hA2);
    a_s_tdata[32 +: 32] = 32'hA3; tick();
    check("lk_d2",    a_m_tdata, 32'hA3);
    a_s_tdata[32 +: 32] = 32'hA4; a_s_tlast[1] = 1'b1; tick();
    check("lk_d3",    a_m_tdata, 32'hA4);
    check("lk_l3",    a_m_tlast, 1'b1);
    check("lk_pkts",  a_sts_packets, 32'd2);
    check("lk_idle",  a_sts_locked, 1'b0);
    check("lk_newsel", a_sts_sel, 2'd3);
    a_beat(3, 32'hC3, 1'b1); tick();
    check("lk_ch3",   a_m_tdata, 32'hC3);
    check("lk_pkts2", a_sts_packets, 32'd3);
    a_s_tvalid = '0; tick();

    // Default-value substitution; cfg_mode change mid-packet is ignored
    a_cfg_sel = 2'd0; a_cfg_mode = 1'b1; a_default = 32'hDEADBEEF;
    a_beat(0, 32'h1, 1'b0); tick();
    check("df_d0", a_m_tdata, 32'hDEADBEEF);
    a_cfg_mode = 1'b0;
    a_beat(0, 32'h2, 1'b0); tick();
    check("df_d1", a_m_tdata, 32'hDEADBEEF);
    a_beat(0, 32'h3, 1'b1); tick();
    check("df_d2", a_m_tdata, 32'hDEADBEEF);
    check("df_l2", a_m_tlast, 1'b1);
    check("df_pkts", a_sts_packets, 32'd4);
    a_s_tvalid = '0; tick();

    // Backpressure: 5-beat stream on channel 2 with stalls
    a_cfg_sel = 2'd2;
    for (int i = 0; i < 5; i++) beats[i] = 32'h51 + 32'(i);
    pat = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    src = 0; outn = 0; was_stalled = 1'b0; held = '0;
    for (int c = 0; c < 12; c++) begin
      a_m_tready = pat[c][0];
      if (src < 5) a_beat(2, beats[src], (src == 4));
      else         a_s_tvalid = '0;
      #1;
      if (was_stalled) check("bp_stable", a_m_tdata, held);
      was_stalled = 1'b0;
      if (a_m_tvalid && a_m_tready) begin
        if (outn < 5) begin
          check("bp_data", a_m_tdata, beats[outn]);
          check("bp_last", a_m_tlast, (outn == 4));
        end else begin
          check("bp_extra_beat", outn, 5);
        end
        outn++;
      end else if (a_m_tvalid) begin
        check("bp_tready_low", a_s_tready[2], 1'b0);
        held = a_m_tdata;
        was_stalled = 1'b1;
      end
      acc = a_s_tvalid[2] && a_s_tready[2];
      tick();
      if (acc) src++;
    end
    check("bp_src_cnt", src, 5);
    check("bp_out_cnt", outn, 5);
    check("bp_pkts", a_sts_packets, 32'd5);
    a_m_tready = 1'b1;

    // Drop instance with out-of-range select
    b_cfg_sel = 3'd5; b_m_tready = 1'b1;
    b_s_tvalid = 4'b1111; b_s_tlast = 4'b1111;
    b_s_tdata = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    #1;
    check("dr_tready", b_s_tready, 4'b1111);
    check("dr_sel",    b_sts_sel,  3'd5);
    repeat (3) begin
      tick();
      check("dr_novalid", b_m_tvalid, 1'b0);
    end
    check("dr_pkts", b_sts_packets, 32'd0);
    b_cfg_sel = 3'd1; #1;
    check("dr_tready_sel", b_s_tready, 4'b1111);
    tick();
    check("dr_d", b_m_tdata, 32'hB1);
    check("dr_v", b_m_tvalid, 1'b1);
    check("dr_pkts1", b_sts_packets, 32'd1);
    b_s_tvalid = '0; tick();

    // Asynchronous reset in the middle of a packet
    a_cfg_sel = 2'd2; a_m_tready = 1'b0;
    a_beat(2, 32'h77, 1'b0); tick();
    check("ar_lock_pre",  a_sts_locked, 1'b1);
    check("ar_valid_pre", a_m_tvalid,   1'b1);
    #2 aresetn = 1'b0;
    #1;
    check("ar_valid",   a_m_tvalid,    1'b0);
    check("ar_pkts",    a_sts_packets, 32'd0);
    check("ar_locked",  a_sts_locked,  1'b0);
    check("ar_tdata",   a_m_tdata,     32'h0);
    check("ar_b_pkts",  b_sts_packets, 32'd0);
    a_s_tvalid = '0;
    tick();
    aresetn = 1'b1;
    tick();
    check("ar_idle", a_sts_locked, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
